// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: operand register file with write-back mux, write-to-read
// bypass, a pending-load scoreboard and a power-up clearing sweep.
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  input  logic              wb_en,
  input  logic              wb_sel,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_mem_data,
  input  logic [DATA_W-1:0] wb_alu_data,
  input  logic              ld_issue,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              hazard,
  output logic              init_done
);

  localparam int DEPTH = 2 ** ADDR_W;
  // One extra bit so the terminal compare can never alias a wrapped pointer.
  localparam logic [ADDR_W:0] PTR_LAST = (ADDR_W + 1)'(DEPTH - 1);

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W:0]     ptr_q, ptr_d;
  logic [DEPTH-1:0]    busy_q, busy_d;
  logic [DATA_W-1:0]   regs_q [DEPTH];

  logic                run;
  logic [DATA_W-1:0]   wdata;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                pend1, pend2;

  assign run       = (state_q == S_RUN);
  assign init_done = run;
  assign wdata     = wb_sel ? wb_mem_data : wb_alu_data;

  // Next-state: sweep pointer, array write port selection and scoreboard update.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d   = state_q;
    ptr_d     = ptr_q;
    busy_d    = busy_q;
    mem_we    = 1'b0;
    mem_waddr = wb_addr;
    mem_wdata = wdata;
    if (!run) begin
      // Sweep: clear one entry per edge; write-back and load issue are ignored.
      mem_we    = 1'b1;
      mem_waddr = ptr_q[ADDR_W-1:0];
      mem_wdata = '0;
      ptr_d     = ptr_q + 1'b1;
      if (ptr_q == PTR_LAST) state_d = S_RUN;
    end else begin
      mem_we = wb_en && !(ZERO_REG && (wb_addr == '0));
      if (wb_en && wb_sel) busy_d[wb_addr] = 1'b0;
      // Set is applied after clear so a newer load to the same register stays pending.
      if (ld_issue && !(ZERO_REG && (ld_addr == '0))) busy_d[ld_addr] = 1'b1;
    end
  end

  // Control state: FSM, sweep pointer and busy bits, all cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      state_q <= S_INIT;
      ptr_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
    end
  end

  // Register array storage.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset so it maps onto plain RAM/flops; the sweep clears it.
    if (mem_we) regs_q[mem_waddr] <= mem_wdata;
  end

  // Read ports with zero-register, bypass and pending-load hazard detection.
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (run && !(ZERO_REG && (rs1_addr == '0)))
      rs1_data = (wb_en && (wb_addr == rs1_addr)) ? wdata : regs_q[rs1_addr];
    if (run && !(ZERO_REG && (rs2_addr == '0)))
      rs2_data = (wb_en && (wb_addr == rs2_addr)) ? wdata : regs_q[rs2_addr];
    // A load returning this cycle is forwarded, so it does not stall.
    pend1  = busy_q[rs1_addr] && !(wb_en && wb_sel && (wb_addr == rs1_addr));
    pend2  = busy_q[rs2_addr] && !(wb_en && wb_sel && (wb_addr == rs2_addr));
    hazard = run && (pend1 || pend2);
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed stimulus pushes expected outputs into a
// scoreboard queue; a monitor pops and compares on each falling edge.
module tb_regfile_scoreboard;

  localparam logic [3:0] M_DONE = 4'b1000;
  localparam logic [3:0] M_HZ   = 4'b0100;
  localparam logic [3:0] M_RS1  = 4'b0010;
  localparam logic [3:0] M_RS2  = 4'b0001;
  localparam logic [3:0] M_ALL  = 4'b1111;

  typedef struct {
    string       name;
    logic [3:0]  mask;
    logic        done;
    logic        hz;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  rs1_addr = '0, rs2_addr = '0, wb_addr = '0, ld_addr = '0;
  logic [31:0] rs1_data, rs2_data, wb_mem_data = '0, wb_alu_data = '0;
  logic        wb_en = 1'b0, wb_sel = 1'b0, ld_issue = 1'b0;
  logic        hazard, init_done;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1)) dut (
    .clk(clk), .rst(rst),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wb_en(wb_en), .wb_sel(wb_sel), .wb_addr(wb_addr),
    .wb_mem_data(wb_mem_data), .wb_alu_data(wb_alu_data),
    .ld_issue(ld_issue), .ld_addr(ld_addr),
    .hazard(hazard), .init_done(init_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: compare the oldest expectation against the settled outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.mask[3]) check({e.name, ".init_done"}, 32'(init_done), 32'(e.done));
        if (e.mask[2]) check({e.name, ".hazard"},    32'(hazard),    32'(e.hz));
        if (e.mask[1]) check({e.name, ".rs1_data"},  rs1_data,       e.rs1);
        if (e.mask[0]) check({e.name, ".rs2_data"},  rs2_data,       e.rs2);
      end
    end
  end

  task automatic expect_out(input string name, input logic [3:0] mask, input logic done,
                            input logic hz, input logic [31:0] r1, input logic [31:0] r2);
    exp_t e;
    e.name = name; e.mask = mask; e.done = done; e.hz = hz; e.rs1 = r1; e.rs2 = r2;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [4:0] a1, input logic [4:0] a2,
                       input logic we, input logic sel, input logic [4:0] wa,
                       input logic [31:0] md, input logic [31:0] ad,
                       input logic li, input logic [4:0] la);
    rs1_addr = a1; rs2_addr = a2; wb_en = we; wb_sel = sel; wb_addr = wa;
    wb_mem_data = md; wb_alu_data = ad; ld_issue = li; ld_addr = la;
  endtask

  task automatic idle(input logic [4:0] a1, input logic [4:0] a2);
    drive(a1, a2, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Release reset just after a falling edge, then count sweep edges.
  task automatic release_and_sweep(input string name, input int edges);
    @(negedge clk);
    #1;
    rst = 1'b0;
    for (int e = 1; e <= edges; e++) begin
      tick();
      // Write-back and load issue are active during most of the sweep and must be ignored.
      if (e <= 30) drive(5'd7, 5'd7, 1'b1, 1'b0, 5'd7, 32'h0, 32'hDEAD_BEEF, 1'b1, 5'd7);
      else idle(5'd7, 5'd7);
      expect_out($sformatf("%s_e%0d", name, e), M_ALL, (e >= 32), 1'b0, 32'h0, 32'h0);
    end
    idle(5'd7, 5'd7);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    idle(5'd7, 5'd7);
    tick();
    expect_out("reset", M_ALL, 1'b0, 1'b0, 32'h0, 32'h0);
    release_and_sweep("init", 32);
    tick();

    // ALU write to r3 with same-cycle read, then read from the array.
    drive(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 32'h0, 32'h0000_00AB, 1'b0, 5'd0);
    expect_out("byp_r3", M_RS1 | M_HZ, 1'b1, 1'b0, 32'hAB, 32'h0);
    tick();
    idle(5'd3, 5'd3);
    expect_out("arr_r3", M_ALL, 1'b1, 1'b0, 32'hAB, 32'hAB);
    tick();

    // r0 is hard-wired to zero and never marked busy.
    drive(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0, 32'hFFFF_FFFF, 1'b1, 5'd0);
    expect_out("r0_wr", M_RS1 | M_HZ, 1'b1, 1'b0, 32'h0, 32'h0);
    tick();
    idle(5'd0, 5'd0);
    expect_out("r0_after", M_RS1 | M_RS2 | M_HZ, 1'b1, 1'b0, 32'h0, 32'h0);
    tick();

    // Load to r5: busy only after the edge, ALU write-back does not clear it.
    drive(5'd5, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd5);
    expect_out("ld5_issue", M_HZ, 1'b1, 1'b0, 32'h0, 32'h0);
    tick();
    idle(5'd0, 5'd5);
    expect_out("ld5_pend", M_HZ, 1'b1, 1'b1, 32'h0, 32'h0);
    tick();
    drive(5'd0, 5'd5, 1'b1, 1'b0, 5'd5, 32'h0, 32'h0000_0077, 1'b0, 5'd0);
    expect_out("ld5_alu", M_HZ | M_RS2, 1'b1, 1'b1, 32'h0, 32'h77);
    tick();
    drive(5'd0, 5'd5, 1'b1, 1'b1, 5'd5, 32'h0000_1234, 32'h0, 1'b0, 5'd0);
    expect_out("ld5_ret", M_HZ | M_RS2, 1'b1, 1'b0, 32'h0, 32'h1234);
    tick();
    idle(5'd0, 5'd5);
    expect_out("ld5_done", M_HZ | M_RS2, 1'b1, 1'b0, 32'h0, 32'h1234);
    tick();

    // Same-edge load issue and mem write-back to r9: set wins.
    drive(5'd9, 5'd0, 1'b1, 1'b1, 5'd9, 32'h0000_0099, 32'h0, 1'b1, 5'd9);
    expect_out("r9_both", M_HZ | M_RS1, 1'b1, 1'b0, 32'h99, 32'h0);
    tick();
    idle(5'd9, 5'd9);
    expect_out("r9_busy", M_ALL, 1'b1, 1'b1, 32'h99, 32'h99);
    tick();
    idle(5'd3, 5'd9);
    expect_out("r9_port2", M_ALL, 1'b1, 1'b1, 32'hAB, 32'h99);
    tick();

    // Reset mid-run, then again at sweep edge 10.
    rst = 1'b1;
    #1;
    expect_out("rst_run", M_ALL, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    release_and_sweep("sweep1", 9);
    rst = 1'b1;
    #1;
    expect_out("rst_mid", M_ALL, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    release_and_sweep("sweep2", 32);
    tick();
    idle(5'd9, 5'd5);
    expect_out("post_rst", M_ALL, 1'b1, 1'b0, 32'h0, 32'h0);
    tick();

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    #1;
    check("sb_drain", 32'(sb.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
